// File: rtl/branch_resolve_ctrl.sv
// ID-stage branch resolution control: detects hazards on branch sources and picks comparator
// forwarding. It sequences branch stalls, issues taken/flush, and keeps saturating statistics.
module branch_resolve_ctrl #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_branch,
  input  logic             id_bne,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             ex_regwrite,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rd,
  input  logic             mem_regwrite,
  input  logic             mem_memread,
  input  logic [4:0]       mem_rd,
  input  logic             cmp_zero,
  output logic             fwd_a,
  output logic             fwd_b,
  output logic             stall,
  output logic             take_branch,
  output logic             flush_ifid,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] taken_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  logic [1:0]       wcnt_d, wcnt_q;
  logic [CNT_W-1:0] branch_cnt_d, branch_cnt_q;
  logic [CNT_W-1:0] taken_cnt_d, taken_cnt_q;
  logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;

  logic dep_a_x, dep_b_x, dep_a_m, dep_b_m;
  logic ex_hit, mem_hit, resolve;

  // $0 is hardwired, so a write to it never creates a dependency.
  assign dep_a_x = ex_regwrite  & (ex_rd  != 5'd0) & (ex_rd  == id_rs);
  assign dep_b_x = ex_regwrite  & (ex_rd  != 5'd0) & (ex_rd  == id_rt);
  assign dep_a_m = mem_regwrite & (mem_rd != 5'd0) & (mem_rd == id_rs);
  assign dep_b_m = mem_regwrite & (mem_rd != 5'd0) & (mem_rd == id_rt);
  assign ex_hit  = dep_a_x | dep_b_x;
  assign mem_hit = dep_a_m | dep_b_m;

  always_comb begin
    stall  = 1'b0;
    fwd_a  = 1'b0;
    fwd_b  = 1'b0;
    wcnt_d = wcnt_q;
    if (wcnt_q != 2'd0) begin
      stall  = 1'b1;
      wcnt_d = wcnt_q - 2'd1;
    end else if (id_branch) begin
      if (ex_hit) begin
        stall = 1'b1;
        // Load result arrives only after MEM, so hold one extra cycle.
        if (ex_memread) wcnt_d = 2'd1;
      end else if (mem_hit & mem_memread) begin
        stall = 1'b1;
      end else begin
        fwd_a = dep_a_m;
        fwd_b = dep_b_m;
      end
    end
    if (reset) begin
      stall  = 1'b0;
      fwd_a  = 1'b0;
      fwd_b  = 1'b0;
      wcnt_d = 2'd0;
    end
  end

  always_comb begin
    resolve     = id_branch & ~stall & ~reset;
    take_branch = resolve & (cmp_zero ^ id_bne);
    flush_ifid  = take_branch;
  end

  always_comb begin
    branch_cnt_d = branch_cnt_q;
    taken_cnt_d  = taken_cnt_q;
    stall_cnt_d  = stall_cnt_q;
    if (reset) begin
      branch_cnt_d = '0;
      taken_cnt_d  = '0;
      stall_cnt_d  = '0;
    end else begin
      if (resolve && (branch_cnt_q != '1)) branch_cnt_d = branch_cnt_q + CNT_W'(1);
      if (take_branch && (taken_cnt_q != '1)) taken_cnt_d = taken_cnt_q + CNT_W'(1);
      // Stalls are only ever raised for branches, so every stall cycle counts.
      if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    wcnt_q       <= wcnt_d;
    branch_cnt_q <= branch_cnt_d;
    taken_cnt_q  <= taken_cnt_d;
    stall_cnt_q  <= stall_cnt_d;
  end

  assign branch_cnt = branch_cnt_q;
  assign taken_cnt  = taken_cnt_q;
  assign stall_cnt  = stall_cnt_q;

endmodule
